// File: rtl/instr_exec_sequencer_if.sv
// Instruction-fetch and result handshake bundle for instr_exec_sequencer.
//   read_pointer            : address driven to the instruction register
//   instr_opcode/operand_a/b: registered instruction word (one cycle after read_pointer)
//   res_valid/res_ready     : result handshake
//   res_data/opcode/ptr/div_zero : result payload, held stable while stalled
// master = sequencer side, slave = register + result consumer side.
interface instr_exec_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int OPND_W = 32,
  parameter int RES_W  = 64
);
  logic        [ADDR_W-1:0] read_pointer;
  logic        [2:0]        instr_opcode;
  logic signed [OPND_W-1:0] instr_operand_a;
  logic signed [OPND_W-1:0] instr_operand_b;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [RES_W-1:0]  res_data;
  logic        [2:0]        res_opcode;
  logic        [ADDR_W-1:0] res_ptr;
  logic                     res_div_zero;

  modport master (
    output read_pointer, res_valid, res_data, res_opcode, res_ptr, res_div_zero,
    input  instr_opcode, instr_operand_a, instr_operand_b, res_ready
  );
  modport slave (
    input  read_pointer, res_valid, res_data, res_opcode, res_ptr, res_div_zero,
    output instr_opcode, instr_operand_a, instr_operand_b, res_ready
  );
endinterface

// File: rtl/instr_exec_sequencer.sv
// Walks a range of instruction-register addresses, executes each instruction
// word (single-cycle ALU ops or a restoring signed divider for DIV/MOD) and
// presents each result on a valid/ready handshake.
//   clk, reset_n : clock, async active-low reset
//   start        : run launch pulse (ignored while busy)
//   first_ptr    : first address of the run, count: number of instructions (0..2**ADDR_W)
//   busy, done   : run in progress / one-cycle end-of-run pulse
//   bus          : instruction fetch + result handshake (master side)
module instr_exec_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OPND_W = 32,
  parameter int RES_W  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   first_ptr,
  input  logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  instr_exec_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(OPND_W + 1);
  localparam logic [2:0] OP_ZERO = 3'd0, OP_PASSA = 3'd1, OP_PASSB = 3'd2, OP_ADD = 3'd3,
                         OP_SUB  = 3'd4, OP_MULT  = 3'd5, OP_DIV   = 3'd6, OP_MOD = 3'd7;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EXEC, DIVIDE, OUTPUT} state_t;
  state_t state, state_nxt;

  logic        [ADDR_W-1:0] ptr;
  logic        [ADDR_W:0]   remaining;
  logic        [2:0]        w_op;
  logic signed [OPND_W-1:0] w_a, w_b;
  logic        [OPND_W-1:0] rem, quo, dvs, abs_a, abs_b;
  logic        [OPND_W:0]   rem_sh, diff;
  logic        [CNT_W-1:0]  dcnt;
  logic signed [RES_W-1:0]  a_x, b_x, alu_res, div_res, mod_res;
  logic        [RES_W-1:0]  q_ext, r_ext;
  logic                     cap_div, accept, last, div_last;

  assign bus.read_pointer = ptr;
  assign cap_div  = (bus.instr_opcode[2:1] == 2'b11) && (bus.instr_operand_b != '0);
  assign accept   = (state == OUTPUT) && bus.res_ready;
  assign last     = (remaining == (ADDR_W+1)'(1));
  assign div_last = (dcnt == CNT_W'(OPND_W));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && count != '0) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = cap_div ? DIVIDE : EXEC;
      EXEC:    state_nxt = OUTPUT;
      DIVIDE:  if (div_last) state_nxt = OUTPUT;
      OUTPUT:  if (accept) state_nxt = last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    abs_a = bus.instr_operand_a[OPND_W-1] ? -bus.instr_operand_a : bus.instr_operand_a;
    abs_b = bus.instr_operand_b[OPND_W-1] ? -bus.instr_operand_b : bus.instr_operand_b;
    a_x   = {{(RES_W-OPND_W){w_a[OPND_W-1]}}, w_a};
    b_x   = {{(RES_W-OPND_W){w_b[OPND_W-1]}}, w_b};
    case (w_op)
      OP_PASSA: alu_res = a_x;
      OP_PASSB: alu_res = b_x;
      OP_ADD:   alu_res = a_x + b_x;
      OP_SUB:   alu_res = a_x - b_x;
      OP_MULT:  alu_res = a_x * b_x;
      default:  alu_res = '0;         // ZERO, and DIV/MOD by zero
    endcase
    // Magnitude quotient is zero-extended first so -2**31 / -1 stays +2**31.
    q_ext   = {{(RES_W-OPND_W){1'b0}}, quo};
    r_ext   = {{(RES_W-OPND_W){1'b0}}, rem};
    div_res = (w_a[OPND_W-1] ^ w_b[OPND_W-1]) ? -q_ext : q_ext;
    mod_res = w_a[OPND_W-1] ? -r_ext : r_ext;
    // Restoring step: partial remainder stays below the divisor, so it
    // always fits OPND_W bits after the subtract-or-keep decision.
    rem_sh  = {rem, quo[OPND_W-1]};
    diff    = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0; remaining <= '0; busy <= 1'b0; done <= 1'b0;
      w_op <= '0; w_a <= '0; w_b <= '0;
      rem <= '0; quo <= '0; dvs <= '0; dcnt <= '0;
      bus.res_valid <= 1'b0; bus.res_data <= '0; bus.res_opcode <= '0;
      bus.res_ptr <= '0; bus.res_div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (count == '0) done <= 1'b1;
          else begin
            ptr <= first_ptr; remaining <= count; busy <= 1'b1;
          end
        end
        CAPTURE: begin
          w_op <= bus.instr_opcode; w_a <= bus.instr_operand_a; w_b <= bus.instr_operand_b;
          rem <= '0; quo <= abs_a; dvs <= abs_b; dcnt <= '0;
        end
        EXEC: begin
          bus.res_valid    <= 1'b1;
          bus.res_data     <= alu_res;
          bus.res_opcode   <= w_op;
          bus.res_ptr      <= ptr;
          bus.res_div_zero <= (w_op == OP_DIV) || (w_op == OP_MOD);
        end
        DIVIDE: if (!div_last) begin
          if (!diff[OPND_W]) begin
            rem <= diff[OPND_W-1:0]; quo <= {quo[OPND_W-2:0], 1'b1};
          end else begin
            rem <= rem_sh[OPND_W-1:0]; quo <= {quo[OPND_W-2:0], 1'b0};
          end
          dcnt <= dcnt + CNT_W'(1);
        end else begin
          bus.res_valid    <= 1'b1;
          bus.res_data     <= (w_op == OP_MOD) ? mod_res : div_res;
          bus.res_opcode   <= w_op;
          bus.res_ptr      <= ptr;
          bus.res_div_zero <= 1'b0;
        end
        OUTPUT: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          remaining     <= remaining - (ADDR_W+1)'(1);
          if (last) begin
            done <= 1'b1; busy <= 1'b0;
          end else ptr <= ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_exec_sequencer.sv
module tb_instr_exec_sequencer;
  localparam int ADDR_W = 5, OPND_W = 32, RES_W = 64;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] first_ptr = '0;
  logic [ADDR_W:0]   count = '0;
  logic busy, done;

  instr_exec_sequencer_if #(.ADDR_W(ADDR_W), .OPND_W(OPND_W), .RES_W(RES_W)) bus();

  instr_exec_sequencer #(.ADDR_W(ADDR_W), .OPND_W(OPND_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr),
    .count(count), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction register: registered read of a 32-entry array.
  logic        [2:0]  m_op [32];
  logic signed [31:0] m_a  [32];
  logic signed [31:0] m_b  [32];
  always @(posedge clk) begin
    bus.instr_opcode    <= m_op[bus.read_pointer];
    bus.instr_operand_a <= m_a[bus.read_pointer];
    bus.instr_operand_b <= m_b[bus.read_pointer];
  end

  // Free-running event counters; tasks look at deltas.
  int done_cnt = 0, busy_cnt = 0, acc_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (bus.res_valid && bus.res_ready) acc_cnt <= acc_cnt + 1;
  end

  int vectors = 0, miscompares = 0;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic longint exp_data(input logic [2:0] op, input int a, input int b);
    longint la = a, lb = b;
    case (op)
      3'd0: return 0;
      3'd1: return la;
      3'd2: return lb;
      3'd3: return la + lb;
      3'd4: return la - lb;
      3'd5: return la * lb;
      3'd6: return (lb == 0) ? 0 : la / lb;
      default: return (lb == 0) ? 0 : la % lb;
    endcase
  endfunction
  function automatic bit exp_dz(input logic [2:0] op, input int b);
    return (op >= 3'd6) && (b == 0);
  endfunction
  function automatic int exp_lat(input logic [2:0] op, input int b);
    return (op >= 3'd6 && b != 0) ? 35 : 3;
  endfunction

  // Observations captured by run_prog.
  logic [63:0] o_data [32];
  logic [2:0]  o_op   [32];
  logic [4:0]  o_ptr  [32];
  logic [4:0]  o_rp   [32];
  bit          o_dz   [32];
  bit          o_stable [32];
  int          o_lat  [32];
  int          n_res;
  bit          timeout, o_done_last, o_busy_after;

  // Launch a run and collect every result; latency counts cycles from the
  // FETCH cycle (first cycle after start or after the previous accept).
  task automatic run_prog(input int first, input int cnt, input int stall, input bit pulse_mid);
    int cyc;
    n_res = 0; timeout = 0;
    start = 1'b1; first_ptr = 5'(first); count = 6'(cnt);
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      cyc = 0;
      o_rp[i] = bus.read_pointer;
      while (!bus.res_valid && cyc < 100) begin
        if (pulse_mid && i == 0 && cyc == 1) begin
          start = 1'b1; count = 6'd5; first_ptr = 5'(first + 7);
        end else start = 1'b0;
        @(posedge clk); #1; cyc++;
      end
      start = 1'b0;
      if (!bus.res_valid) begin timeout = 1; break; end
      o_lat[i] = cyc; o_data[i] = bus.res_data; o_op[i] = bus.res_opcode;
      o_ptr[i] = bus.res_ptr; o_dz[i] = bus.res_div_zero; o_stable[i] = 1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (bus.res_valid !== 1'b1 || bus.res_data !== o_data[i] || bus.res_opcode !== o_op[i] ||
            bus.res_ptr !== o_ptr[i] || bus.res_div_zero !== o_dz[i]) o_stable[i] = 0;
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      n_res++;
    end
    o_done_last = done; o_busy_after = busy;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.read_pointer, bus.res_valid, bus.res_opcode, bus.res_ptr, bus.res_div_zero, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctl: rp=%0d valid=%b op=%0d ptr=%0d dz=%b busy=%b done=%b, required all 0",
               bus.read_pointer, bus.res_valid, bus.res_opcode, bus.res_ptr, bus.res_div_zero, busy, done);
    end
    vectors++;
    if (bus.res_data !== 64'd0) begin
      miscompares++; $display("FAIL reset_data: got %0d required 0", bus.res_data);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    longint req [3];
    int d0;
    req[0] = -2; req[1] = -13; req[2] = -64'sd4900000000;
    m_op[0] = 3'd3; m_a[0] = 5;      m_b[0] = -7;
    m_op[1] = 3'd4; m_a[1] = -3;     m_b[1] = 10;
    m_op[2] = 3'd5; m_a[2] = -70000; m_b[2] = 70000;
    d0 = done_cnt;
    run_prog(0, 3, 0, 0);
    vectors++;
    if (timeout || n_res != 3) begin miscompares++; $display("FAIL alu_count: got %0d results required 3", n_res); end
    for (int i = 0; i < n_res; i++) begin
      vectors++;
      if ({o_data[i], o_ptr[i], o_op[i], o_dz[i]} !== {req[i], 5'(i), m_op[i], 1'b0}) begin
        miscompares++;
        $display("FAIL alu_res%0d: got data=%0d ptr=%0d op=%0d dz=%b required data=%0d ptr=%0d op=%0d dz=0",
                 i, $signed(o_data[i]), o_ptr[i], o_op[i], o_dz[i], req[i], i, m_op[i]);
      end
      vectors++;
      if (o_lat[i] != 3) begin miscompares++; $display("FAIL alu_lat%0d: got %0d required 3", i, o_lat[i]); end
    end
    @(posedge clk); #1;
    vectors++;
    if (!o_done_last || o_busy_after || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL alu_done: done_after_accept=%b busy=%b pulses=%0d required 1,0,1", o_done_last, o_busy_after, done_cnt - d0);
    end
  endtask

  task automatic test_div_signs();
    longint req [4];
    req[0] = -3; req[1] = -2; req[2] = -3; req[3] = 64'sd2147483648;
    m_op[4] = 3'd6; m_a[4] = -17;          m_b[4] = 5;
    m_op[5] = 3'd7; m_a[5] = -17;          m_b[5] = 5;
    m_op[6] = 3'd6; m_a[6] = 17;           m_b[6] = -5;
    m_op[7] = 3'd6; m_a[7] = 32'h80000000; m_b[7] = -1;
    run_prog(4, 4, 0, 0);
    vectors++;
    if (timeout || n_res != 4) begin miscompares++; $display("FAIL div_count: got %0d results required 4", n_res); end
    for (int i = 0; i < n_res; i++) begin
      vectors++;
      if ({o_data[i], o_dz[i], o_ptr[i]} !== {req[i], 1'b0, 5'(4 + i)}) begin
        miscompares++;
        $display("FAIL div_res%0d: got data=%0d dz=%b ptr=%0d required data=%0d dz=0 ptr=%0d",
                 i, $signed(o_data[i]), o_dz[i], o_ptr[i], req[i], 4 + i);
      end
      vectors++;
      if (o_lat[i] != 35) begin miscompares++; $display("FAIL div_lat%0d: got %0d required 35", i, o_lat[i]); end
    end
  endtask

  task automatic test_div_zero();
    m_op[8] = 3'd6; m_a[8] = 9; m_b[8] = 0;
    m_op[9] = 3'd7; m_a[9] = 9; m_b[9] = 0;
    run_prog(8, 2, 0, 0);
    vectors++;
    if (timeout || n_res != 2) begin miscompares++; $display("FAIL dz_count: got %0d results required 2", n_res); end
    for (int i = 0; i < n_res; i++) begin
      vectors++;
      if ({o_data[i], o_dz[i], o_op[i]} !== {64'd0, 1'b1, m_op[8 + i]} || o_lat[i] != 3) begin
        miscompares++;
        $display("FAIL dz_res%0d: got data=%0d dz=%b op=%0d lat=%0d required 0,1,%0d,3",
                 i, $signed(o_data[i]), o_dz[i], o_op[i], o_lat[i], m_op[8 + i]);
      end
    end
  endtask

  task automatic test_backpressure_wrap();
    int a0, idx;
    for (int k = 0; k < 4; k++) begin
      idx = (30 + k) % 32;
      m_op[idx] = 3'($urandom_range(0, 7)); m_a[idx] = $urandom; m_b[idx] = $urandom_range(0, 1) ? 0 : $urandom;
    end
    a0 = acc_cnt;
    run_prog(30, 4, 10, 0);
    @(posedge clk); #1;
    vectors++;
    if (timeout || n_res != 4 || acc_cnt - a0 != 4) begin
      miscompares++; $display("FAIL bp_accepts: got %0d accepts required 4", acc_cnt - a0);
    end
    for (int i = 0; i < n_res; i++) begin
      idx = (30 + i) % 32;
      vectors++;
      if ({o_rp[i], o_ptr[i], o_stable[i]} !== {5'(idx), 5'(idx), 1'b1}) begin
        miscompares++;
        $display("FAIL bp_ptr%0d: got rp=%0d ptr=%0d stable=%b required %0d,%0d,1", i, o_rp[i], o_ptr[i], o_stable[i], idx, idx);
      end
      vectors++;
      if ({o_data[i], o_dz[i]} !== {exp_data(m_op[idx], m_a[idx], m_b[idx]), exp_dz(m_op[idx], m_b[idx])}) begin
        miscompares++;
        $display("FAIL bp_res%0d: got data=%0d dz=%b required %0d,%b", i, $signed(o_data[i]), o_dz[i],
                 exp_data(m_op[idx], m_a[idx], m_b[idx]), exp_dz(m_op[idx], m_b[idx]));
      end
    end
  endtask

  task automatic test_edge_starts();
    int b0, a0;
    b0 = busy_cnt;
    bus.res_ready = 1'b1;               // ready while nothing is valid must be harmless
    start = 1'b1; count = '0; first_ptr = 5'd3;
    @(posedge clk); #1; start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL zero_count: done=%b busy=%b required 1,0", done, busy);
    end
    @(posedge clk); #1; bus.res_ready = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy_cnt != b0 || bus.res_valid !== 1'b0) begin
      miscompares++; $display("FAIL zero_count_after: done=%b busy_cycles=%0d valid=%b required 0,0,0", done, busy_cnt - b0, bus.res_valid);
    end
    for (int k = 10; k < 13; k++) begin
      m_op[k] = 3'($urandom_range(0, 5)); m_a[k] = $urandom; m_b[k] = $urandom;
    end
    a0 = acc_cnt;
    run_prog(10, 3, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (timeout || n_res != 3 || acc_cnt - a0 != 3 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_ignored: results=%0d accepts=%0d busy=%b valid=%b required 3,3,0,0", n_res, acc_cnt - a0, busy, bus.res_valid);
    end
    for (int i = 0; i < n_res; i++) begin
      vectors++;
      if ({o_ptr[i], o_data[i]} !== {5'(10 + i), exp_data(m_op[10 + i], m_a[10 + i], m_b[10 + i])}) begin
        miscompares++;
        $display("FAIL restart_res%0d: got ptr=%0d data=%0d required %0d,%0d", i, o_ptr[i], $signed(o_data[i]),
                 10 + i, exp_data(m_op[10 + i], m_a[10 + i], m_b[10 + i]));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int d0;
    m_op[0] = 3'd6; m_a[0] = 100; m_b[0] = 7;
    d0 = done_cnt;
    start = 1'b1; first_ptr = '0; count = 6'd2;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    vectors++;
    if ({bus.read_pointer, bus.res_valid, bus.res_opcode, bus.res_ptr, bus.res_div_zero, busy, done} !== '0 ||
        bus.res_data !== 64'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: rp=%0d valid=%b data=%0d busy=%b done=%b required all 0",
               bus.read_pointer, bus.res_valid, bus.res_data, busy, done);
    end
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt != d0) begin miscompares++; $display("FAIL midrun_done: got %0d pulses required 0", done_cnt - d0); end
    run_prog(0, 1, 0, 0);
    vectors++;
    if (timeout || n_res != 1 || o_data[0] !== 64'd14 || o_lat[0] != 35 || !o_done_last) begin
      miscompares++;
      $display("FAIL midrun_rerun: results=%0d data=%0d lat=%0d done=%b required 1,14,35,1", n_res, $signed(o_data[0]), o_lat[0], o_done_last);
    end
  endtask

  task automatic test_random();
    int first, cnt, idx, sel;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) begin
        m_op[k] = 3'($urandom_range(0, 7));
        m_a[k]  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        sel = $urandom_range(0, 3);
        m_b[k]  = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 20) : (sel == 2) ? -1 : $urandom;
        if ($urandom_range(0, 1) == 1) m_a[k] = m_a[k] >>> 20;
      end
      first = $urandom_range(0, 31);
      cnt   = (r == 3) ? 32 : $urandom_range(1, 12);
      run_prog(first, cnt, $urandom_range(0, 2), 0);
      vectors++;
      if (timeout || n_res != cnt || !o_done_last) begin
        miscompares++; $display("FAIL rand_run%0d: results=%0d done=%b required %0d,1", r, n_res, o_done_last, cnt);
      end
      for (int i = 0; i < n_res; i++) begin
        idx = (first + i) % 32;
        vectors++;
        if ({o_data[i], o_dz[i], o_op[i], o_ptr[i], o_rp[i]} !==
            {exp_data(m_op[idx], m_a[idx], m_b[idx]), exp_dz(m_op[idx], m_b[idx]), m_op[idx], 5'(idx), 5'(idx)}) begin
          miscompares++;
          $display("FAIL rand%0d_res%0d: got data=%0d dz=%b op=%0d ptr=%0d rp=%0d required %0d,%b,%0d,%0d,%0d (a=%0d b=%0d)",
                   r, i, $signed(o_data[i]), o_dz[i], o_op[i], o_ptr[i], o_rp[i],
                   exp_data(m_op[idx], m_a[idx], m_b[idx]), exp_dz(m_op[idx], m_b[idx]), m_op[idx], idx, idx, m_a[idx], m_b[idx]);
        end
        vectors++;
        if (o_lat[i] != exp_lat(m_op[idx], m_b[idx])) begin
          miscompares++;
          $display("FAIL rand%0d_lat%0d: got %0d required %0d", r, i, o_lat[i], exp_lat(m_op[idx], m_b[idx]));
        end
      end
    end
  endtask

  initial begin
    bus.res_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin m_op[k] = '0; m_a[k] = '0; m_b[k] = '0; end
    test_reset();
    test_alu();
    test_div_signs();
    test_div_zero();
    test_backpressure_wrap();
    test_edge_starts();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
